// File: rtl/flappy_engine.sv
// flappy_engine: once-per-frame game state (bird, pipes, coin, score, status) for the VGA display.
// Coin pickup is built only when FLAPPY_COIN_EN is defined; otherwise coin is constant 0.
module flappy_engine #(
    parameter int          MARIO_X      = 70,
    parameter int          OBJ_W        = 16,
    parameter int          PIPE_W       = 50,
    parameter int          Y_START      = 200,
    parameter int          GRAVITY      = 1,
    parameter int          FLAP_V       = 7,
    parameter int          MAX_FALL     = 8,
    parameter int          PIPE_SPACING = 220,
    parameter int          COIN_BONUS   = 5,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_flap,
    input  logic        btn_sel,
    output logic [1:0]  status,
    output logic [15:0] score,
    output logic [15:0] mario,
    output logic [31:0] pipe_1,
    output logic [31:0] pipe_2,
    output logic [31:0] pipe_3,
    output logic [31:0] coin
);

    // The state encoding is the status code itself, so status is a plain register.
    typedef enum logic [1:0] {
        ST_OVER  = 2'b00,
        ST_MENU0 = 2'b01,
        ST_MENU1 = 2'b10,
        ST_PLAY  = 2'b11
    } state_t;

    localparam logic [10:0]        MX     = 11'(MARIO_X);
    localparam logic [10:0]        OW     = 11'(OBJ_W);
    localparam logic [10:0]        PW     = 11'(PIPE_W);
    localparam logic [10:0]        WRAP   = 11'(3 * PIPE_SPACING);
    localparam logic [10:0]        GROUND = 11'd480;
    localparam logic signed [6:0]  V_MAX  = 7'(MAX_FALL);
    localparam logic signed [6:0]  V_GRAV = 7'(GRAVITY);
    localparam logic signed [5:0]  V_FLAP = 6'(-FLAP_V);

    state_t             state;
    logic [1:0]         speed;
    logic [7:0]         gap;
    logic [9:0]         bird_y;
    logic signed [5:0]  bird_v;
    logic [3:0]         wing_cnt;
    logic               wing_flag;
    logic [15:0]        lfsr;
    logic [15:0]        score_r;
    logic [9:0]         pa [3];
    logic [9:0]         ph [3];
    logic [7:0]         pg [3];
    logic               btn_flap_q;
    logic               btn_sel_q;
    logic               flap_pend;
    logic               sel_pend;

    logic               flap_rise;
    logic               sel_rise;
    logic               flap_ev;
    logic               sel_ev;
    logic               start_mode;
    logic [7:0]         start_gap;
    logic signed [6:0]  v_sum;
    logic signed [5:0]  v_mid;
    logic signed [5:0]  v_new;
    logic signed [11:0] y_sum;
    logic [9:0]         y_new;
    logic [3:0]         wing_cnt_n;
    logic [10:0]        a_wrap [3];
    logic [9:0]         pa_n [3];
    logic [9:0]         ph_n [3];
    logic [7:0]         pg_n [3];
    logic [2:0]         resp;
    logic [2:0]         pass;
    logic [2:0]         hit_pipe;
    logic               hit;
    logic [15:0]        lfsr_n;
    logic [16:0]        bonus;
    logic [16:0]        score_sum;
    logic [15:0]        score_n;

`ifdef FLAPPY_COIN_EN
    logic               coin_vis;
    logic [9:0]         coin_x;
    logic [9:0]         coin_y;
    logic [9:0]         cx_n;
    logic [9:0]         cy_n;
    logic               cvis_mid;
    logic               coin_hit;
`endif

    assign flap_rise  = btn_flap & ~btn_flap_q;
    assign sel_rise   = btn_sel & ~btn_sel_q;
    // An edge landing on the tick cycle itself is consumed by that tick.
    assign flap_ev    = flap_pend | flap_rise;
    assign sel_ev     = sel_pend | sel_rise;
    assign start_mode = (state == ST_MENU1);
    assign start_gap  = start_mode ? 8'd110 : 8'd140;

    always_comb begin
        v_sum = {bird_v[5], bird_v} + V_GRAV;
        if (flap_ev) begin
            v_mid      = V_FLAP;
            wing_cnt_n = 4'd8;
        end else begin
            v_mid      = (v_sum > V_MAX) ? V_MAX[5:0] : v_sum[5:0];
            wing_cnt_n = (wing_cnt != 4'd0) ? wing_cnt - 4'd1 : 4'd0;
        end
        y_sum = $signed({2'b00, bird_y}) + $signed({{6{v_mid[5]}}, v_mid});
        if (y_sum[11]) begin
            y_new = 10'd0;
            v_new = 6'sd0;
        end else begin
            y_new = y_sum[9:0];
            v_new = v_mid;
        end

        // Pipes respawn in index order; each respawn draws the current LFSR value then steps it.
        lfsr_n = lfsr;
        for (int i = 0; i < 3; i++) begin
            resp[i]   = (pa[i] < {8'd0, speed});
            a_wrap[i] = {1'b0, pa[i]} + WRAP - {9'd0, speed};
            if (resp[i]) begin
                pa_n[i] = a_wrap[i][9:0];
                ph_n[i] = 10'd64 + {2'd0, lfsr_n[7:0]};
                pg_n[i] = gap;
                lfsr_n  = {lfsr_n[0] ^ lfsr_n[2] ^ lfsr_n[3] ^ lfsr_n[5], lfsr_n[15:1]};
            end else begin
                pa_n[i] = pa[i] - {8'd0, speed};
                ph_n[i] = ph[i];
                pg_n[i] = pg[i];
            end
            pass[i]     = ({1'b0, pa[i]} + PW >= MX) && ({1'b0, pa_n[i]} + PW < MX);
            hit_pipe[i] = ({1'b0, pa_n[i]} < MX + OW) && ({1'b0, pa_n[i]} + PW > MX) &&
                          (({1'b0, y_new} < {1'b0, ph_n[i]}) ||
                           ({1'b0, y_new} + OW > {1'b0, ph_n[i]} + {3'd0, pg_n[i]} - 11'd1));
        end
        hit = (|hit_pipe) || ({1'b0, y_new} + OW >= GROUND);

        bonus = 17'd0;
`ifdef FLAPPY_COIN_EN
        cx_n     = pa_n[1] + 10'd17;
        cy_n     = ph_n[1] + {3'd0, pg_n[1][7:1]} - 10'd8;
        cvis_mid = resp[1] | coin_vis;
        coin_hit = cvis_mid &&
                   ({1'b0, cx_n} < MX + OW) && ({1'b0, cx_n} + OW > MX) &&
                   ({1'b0, cy_n} < {1'b0, y_new} + OW) && ({1'b0, cy_n} + OW > {1'b0, y_new});
        if (coin_hit) bonus = 17'(COIN_BONUS);
`endif
        score_sum = {1'b0, score_r} + 17'(pass[0]) + 17'(pass[1]) + 17'(pass[2]) + bonus;
        score_n   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_MENU0;
            speed      <= 2'd2;
            gap        <= 8'd140;
            bird_y     <= 10'(Y_START);
            bird_v     <= 6'sd0;
            wing_cnt   <= 4'd0;
            wing_flag  <= 1'b0;
            lfsr       <= SEED;
            score_r    <= 16'd0;
            pa[0]      <= 10'd460;
            ph[0]      <= 10'd160;
            pa[1]      <= 10'd680;
            ph[1]      <= 10'd200;
            pa[2]      <= 10'd900;
            ph[2]      <= 10'd120;
            pg[0]      <= 8'd140;
            pg[1]      <= 8'd140;
            pg[2]      <= 8'd140;
            btn_flap_q <= 1'b0;
            btn_sel_q  <= 1'b0;
            flap_pend  <= 1'b0;
            sel_pend   <= 1'b0;
`ifdef FLAPPY_COIN_EN
            coin_vis   <= 1'b1;
            coin_x     <= 10'd697;
            coin_y     <= 10'd222;
`endif
        end else begin
            btn_flap_q <= btn_flap;
            btn_sel_q  <= btn_sel;
            if (!frame_tick) begin
                if (flap_rise) flap_pend <= 1'b1;
                if (sel_rise)  sel_pend  <= 1'b1;
            end else begin
                flap_pend <= 1'b0;
                sel_pend  <= 1'b0;
                case (state)
                    ST_MENU0, ST_MENU1: begin
                        if (flap_ev) begin
                            state     <= ST_PLAY;
                            speed     <= start_mode ? 2'd3 : 2'd2;
                            gap       <= start_gap;
                            score_r   <= 16'd0;
                            bird_y    <= 10'(Y_START);
                            bird_v    <= 6'sd0;
                            wing_cnt  <= 4'd0;
                            wing_flag <= 1'b0;
                            pa[0]     <= 10'd460;
                            ph[0]     <= 10'd160;
                            pa[1]     <= 10'd680;
                            ph[1]     <= 10'd200;
                            pa[2]     <= 10'd900;
                            ph[2]     <= 10'd120;
                            pg[0]     <= start_gap;
                            pg[1]     <= start_gap;
                            pg[2]     <= start_gap;
`ifdef FLAPPY_COIN_EN
                            coin_vis  <= 1'b1;
                            coin_x    <= 10'd697;
                            coin_y    <= 10'd192 + {3'd0, start_gap[7:1]};
`endif
                        end else if (sel_ev) begin
                            state <= (state == ST_MENU0) ? ST_MENU1 : ST_MENU0;
                        end
                    end
                    ST_PLAY: begin
                        bird_y    <= y_new;
                        bird_v    <= v_new;
                        wing_cnt  <= wing_cnt_n;
                        wing_flag <= (wing_cnt_n != 4'd0);
                        lfsr      <= lfsr_n;
                        score_r   <= score_n;
                        for (int i = 0; i < 3; i++) begin
                            pa[i] <= pa_n[i];
                            ph[i] <= ph_n[i];
                            pg[i] <= pg_n[i];
                        end
`ifdef FLAPPY_COIN_EN
                        coin_x   <= cx_n;
                        coin_y   <= cy_n;
                        coin_vis <= cvis_mid & ~coin_hit;
`endif
                        if (hit) state <= ST_OVER;
                    end
                    default: begin
                        if (flap_ev) state <= ST_MENU0;
                    end
                endcase
            end
        end
    end

    assign status = state;
    assign score  = score_r;
    assign mario  = {wing_flag, 5'd0, bird_y};
    assign pipe_1 = {4'd0, pg[0], pa[0], ph[0]};
    assign pipe_2 = {4'd0, pg[1], pa[1], ph[1]};
    assign pipe_3 = {4'd0, pg[2], pa[2], ph[2]};
`ifdef FLAPPY_COIN_EN
    assign coin   = {coin_vis, 11'd0, coin_y, coin_x};
`else
    assign coin   = 32'd0;
`endif

endmodule

// File: tb/tb_flappy_engine.sv
// Randomized scoreboard bench for flappy_engine: a frame-level game model predicts every output
// bus after each frame_tick, and a monitor compares the DUT one clk after the tick.
module tb_flappy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        btn_flap;
    logic        btn_sel;
    logic [1:0]  status;
    logic [15:0] score;
    logic [15:0] mario;
    logic [31:0] pipe_1;
    logic [31:0] pipe_2;
    logic [31:0] pipe_3;
    logic [31:0] coin;

    flappy_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_flap   (btn_flap),
        .btn_sel    (btn_sel),
        .status     (status),
        .score      (score),
        .mario      (mario),
        .pipe_1     (pipe_1),
        .pipe_2     (pipe_2),
        .pipe_3     (pipe_3),
        .coin       (coin)
    );

    always #5 clk = ~clk;

    // Expected bus image: {status, score, mario, pipe_1, pipe_2, pipe_3, coin}.
    logic [161:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Game model, kept as plain integers.
    int m_st;
    int m_speed, m_gap;
    int m_y, m_v, m_wing, m_score;
    int m_a[3], m_h[3], m_g[3];
    int m_lfsr;
    bit m_flap, m_sel;
    int m_cx, m_cy;
    bit m_cvis;
    int n_pass = 0, n_resp = 0, n_over = 0, n_coin = 0;
    bit did_reset = 0;

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    task automatic model_init(input int g);
        m_a = '{460, 680, 900};
        m_h = '{160, 200, 120};
        m_g = '{g, g, g};
        m_y = 200;
        m_v = 0;
        m_wing = 0;
        m_cx = m_a[1] + 17;
        m_cy = m_h[1] + g / 2 - 8;
        m_cvis = 1;
    endtask

    task automatic model_reset();
        m_st = 1;
        m_speed = 2;
        m_gap = 140;
        model_init(140);
        m_cx = 697;
        m_cy = 222;
        m_score = 0;
        m_lfsr = 16'hACE1;
        m_flap = 0;
        m_sel = 0;
    endtask

    task automatic model_play();
        int gain, old;
        bit hit;
        if (m_flap) begin
            m_v = -7;
            m_wing = 8;
        end else begin
            m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
            if (m_wing > 0) m_wing--;
        end
        m_y += m_v;
        if (m_y < 0) begin
            m_y = 0;
            m_v = 0;
        end
        gain = 0;
        hit = 0;
        for (int i = 0; i < 3; i++) begin
            old = m_a[i];
            if (old < m_speed) begin
                m_a[i] = old - m_speed + 660;
                m_h[i] = 64 + (m_lfsr & 255);
                m_g[i] = m_gap;
                m_lfsr = lfsr_next(m_lfsr);
                if (i == 1) m_cvis = 1;
                n_resp++;
            end else begin
                m_a[i] = old - m_speed;
            end
            if (old + 50 >= 70 && m_a[i] + 50 < 70) begin
                gain++;
                n_pass++;
            end
            if (m_a[i] < 86 && m_a[i] + 50 > 70 && (m_y < m_h[i] || m_y + 16 > m_h[i] + m_g[i] - 1))
                hit = 1;
        end
        if (m_y + 16 >= 480) hit = 1;
`ifdef FLAPPY_COIN_EN
        m_cx = m_a[1] + 17;
        m_cy = m_h[1] + m_g[1] / 2 - 8;
        if (m_cvis && m_cx < 86 && m_cx + 16 > 70 && m_cy < m_y + 16 && m_cy + 16 > m_y) begin
            m_cvis = 0;
            gain += 5;
            n_coin++;
        end
`endif
        m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
        if (hit) begin
            m_st = 0;
            n_over++;
        end
    endtask

    function automatic logic [161:0] model_pack();
        logic [31:0] p[3];
        logic [31:0] c;
        for (int i = 0; i < 3; i++) p[i] = {4'd0, 8'(m_g[i]), 10'(m_a[i]), 10'(m_h[i])};
`ifdef FLAPPY_COIN_EN
        c = {m_cvis, 11'd0, 10'(m_cy), 10'(m_cx)};
`else
        c = 32'd0;
`endif
        return {2'(m_st), 16'(m_score), (m_wing > 0), 5'd0, 10'(m_y), p[0], p[1], p[2], c};
    endfunction

    task automatic model_tick();
        case (m_st)
            1, 2: begin
                if (m_flap) begin
                    m_speed = (m_st == 2) ? 3 : 2;
                    m_gap = (m_st == 2) ? 110 : 140;
                    model_init(m_gap);
                    m_score = 0;
                    m_st = 3;
                end else if (m_sel) begin
                    m_st = 3 - m_st;
                end
            end
            3: model_play();
            default: if (m_flap) m_st = 1;
        endcase
        m_flap = 0;
        m_sel = 0;
        exp_q.push_back(model_pack());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [161:0] e);
        chk("status", 32'(status), 32'(e[161:160]));
        chk("score",  32'(score),  32'(e[159:144]));
        chk("mario",  32'(mario),  32'(e[143:128]));
        chk("pipe_1", pipe_1, e[127:96]);
        chk("pipe_2", pipe_2, e[95:64]);
        chk("pipe_3", pipe_3, e[63:32]);
        chk("coin",   coin,   e[31:0]);
    endtask

    task automatic press(input bit is_flap);
        @(negedge clk);
        if (is_flap) btn_flap = 1'b1;
        else btn_sel = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
        btn_sel = 1'b0;
        if (is_flap) m_flap = 1;
        else m_sel = 1;
    endtask

    task automatic tick();
        model_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Steers toward the centre of the next gap, with some random wrong decisions.
    function automatic bit autopilot();
        int best, target;
        bit f;
        best = -1;
        for (int i = 0; i < 3; i++)
            if (m_a[i] + 50 >= 70 && (best < 0 || m_a[i] < m_a[best])) best = i;
        target = (best < 0) ? 200 : m_h[best] + m_g[best] / 2 - 8;
        f = (m_y > target + 4) && (m_v >= 0);
        if ($urandom_range(0, 99) < 8) f = !f;
        return f;
    endfunction

    initial begin : monitor
        logic [161:0] e;
        forever begin
            @(posedge clk);
            if (frame_tick && !rst) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard: DUT update with no expected entry (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk_all(e);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int r;
        rst = 1'b1;
        frame_tick = 1'b0;
        btn_flap = 1'b0;
        btn_sel = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all(model_pack());
        rst = 1'b0;

        // Menu toggle, start in mode 0, then free fall from rest.
        press(0); tick();
        press(0); tick();
        press(1); tick();
        repeat (6) tick();

        for (int f = 0; f < 1500; f++) begin
            if (f >= 700 && !did_reset && m_st == 3) begin
                @(negedge clk);
                #1 rst = 1'b1;
                model_reset();
                #1 chk_all(model_pack());
                @(negedge clk);
                rst = 1'b0;
                did_reset = 1;
            end
            case (m_st)
                3: begin
                    if (autopilot()) press(1);
                    else if ($urandom_range(0, 99) < 3) press(0);
                end
                0: if ($urandom_range(0, 99) < 20) press(1);
                default: begin
                    r = $urandom_range(0, 99);
                    if (r < 25) press(0);
                    else if (r < 55) press(1);
                end
            endcase
            tick();
        end

        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("info: passes=%0d respawns=%0d game_overs=%0d coins=%0d mid_reset=%0d",
                 n_pass, n_resp, n_over, n_coin, did_reset);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
